// File: rtl/rf_wr_port_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package rf_wr_port_arb_pkg;

    localparam int         RF_ADDR_W    = 5;
    localparam int         RF_NUM_REGS  = 32;
    localparam logic [4:0] REG_X0       = 5'd0;
    localparam logic [3:0] STARVE_LIMIT = 4'd15;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_st_e;

endpackage

// File: rtl/rf_wr_port_arb_dec5.sv
// 5-to-32 one-hot decoder for register-file word enables.
module rf_wr_port_arb_dec5
    import rf_wr_port_arb_pkg::*;
(
    input  logic [RF_ADDR_W-1:0]   addr,
    output logic [RF_NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot       = '0;
        onehot[addr] = 1'b1;
    end

endmodule

// File: rtl/rf_wr_port_arb.sv
// Round-robin arbiter for the single RF write port, one registered output stage.
// Optional starvation override: define RF_WR_ARB_STARVE_EN.
module rf_wr_port_arb
    import rf_wr_port_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_aL,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*5-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      wr_stall,
    output logic                      wr_valid,
    output logic [RF_NUM_REGS-1:0]    wr_en,
    output logic [RF_ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [2:0]                grant_id
);

    stage_st_e            state;
    logic [2:0]           rr_ptr;
    logic [2:0]           rr_nxt;
    logic [2:0]           pick;
    logic                 pick_vld;
    logic                 advance;
    logic                 grant;
    logic [RF_ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0]    pick_data;
    logic [RF_NUM_REGS-1:0] dec_en;

`ifdef RF_WR_ARB_STARVE_EN
    logic [3:0]         wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] sat;

    always_comb begin
        for (int j = 0; j < NUM_REQ; j++)
            sat[j] = req_valid[j] && (wait_cnt[j] == STARVE_LIMIT);
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            for (int j = 0; j < NUM_REQ; j++)
                wait_cnt[j] <= '0;
        end else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!req_valid[j] || req_ready[j])
                    wait_cnt[j] <= '0;
                else if (wait_cnt[j] != STARVE_LIMIT)
                    wait_cnt[j] <= wait_cnt[j] + 4'd1;
            end
        end
    end
`endif

    assign wr_valid = (state == ST_FULL);
    assign advance  = !wr_valid || !wr_stall;

    // Smallest circular distance from rr_ptr wins.
    always_comb begin
        int d;
        int best;
        pick_vld = 1'b0;
        pick     = '0;
        best     = NUM_REQ;
        d        = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            d = j - int'(rr_ptr);
            if (d < 0)
                d = d + NUM_REQ;
            if (req_valid[j] && d < best) begin
                best     = d;
                pick     = 3'(j);
                pick_vld = 1'b1;
            end
        end
`ifdef RF_WR_ARB_STARVE_EN
        if (|sat) begin
            for (int j = NUM_REQ - 1; j >= 0; j--) begin
                if (sat[j])
                    pick = 3'(j);
            end
        end
`endif
    end

    assign grant  = rst_aL && advance && pick_vld;
    assign rr_nxt = (int'(pick) == NUM_REQ - 1) ? 3'd0 : pick + 3'd1;

    always_comb begin
        req_ready = '0;
        pick_addr = '0;
        pick_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            req_ready[j] = grant && (pick == 3'(j));
            if (pick == 3'(j)) begin
                pick_addr = req_addr[5*j +: 5];
                pick_data = req_data[DATA_W*j +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state    <= ST_EMPTY;
            wr_addr  <= '0;
            wr_data  <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            if (grant)
                rr_ptr <= rr_nxt;
            if (advance) begin
                // x0 writes handshake but never occupy the stage.
                if (grant && pick_addr != REG_X0) begin
                    state    <= ST_FULL;
                    wr_addr  <= pick_addr;
                    wr_data  <= pick_data;
                    grant_id <= pick;
                end else begin
                    state <= ST_EMPTY;
                end
            end
        end
    end

    rf_wr_port_arb_dec5 u_dec5 (
        .addr   (wr_addr),
        .onehot (dec_en)
    );

    assign wr_en = dec_en & {RF_NUM_REGS{wr_valid}};

endmodule
